// File: rtl/imem_rd_arb_pkg.sv
// rtl/imem_rd_arb_pkg.sv - shared types and constants for the instruction-memory read arbiter
package imem_rd_arb_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam int          STAGE_DATA_W  = 32;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DP = 1'b1
  } owner_e;

  typedef struct packed {
    logic                    valid;
    owner_e                  owner;
    logic                    err;
    logic [STAGE_DATA_W-1:0] data;
  } stage_t;

  // req[0] is IF, req[1] is DP; returns the granted owner for a non-empty request
  function automatic owner_e gnt_owner(input logic [1:0] gnt);
    return gnt[1] ? OWN_DP : OWN_IF;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with last-winner register
module rr_arb2
  import imem_rd_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt,
  output owner_e     rr_last
);

  always_comb begin
    gnt = req;
    // contention: the port that did not win last time goes first
    if (req == 2'b11) begin
      gnt = (rr_last == OWN_DP) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last <= OWN_DP;
    end else if (accept) begin
      rr_last <= gnt_owner(gnt);
    end
  end

endmodule

// File: rtl/imem_rd_arbiter.sv
// rtl/imem_rd_arbiter.sv - IF/DP round-robin sharing of one sync-read imem port, 2-cycle in-order responses
// Optional address checking with NOP/error responses: define IMEM_RD_ARB_ADDR_CHK_EN
module imem_rd_arbiter
  import imem_rd_arb_pkg::*;
#(
  parameter int                 ADDR_W    = 7,
  parameter int                 DATA_W    = 32,
  parameter logic [DATA_W-1:0]  NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              if_valid,
  input  logic [31:0]       if_addr,
  output logic              if_ready,
  input  logic              if_flush,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,

  input  logic              dp_valid,
  input  logic [31:0]       dp_addr,
  output logic              dp_ready,
  output logic              dp_rsp_valid,
  output logic [DATA_W-1:0] dp_rsp_data,
  output logic              dp_rsp_err,

  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              accept;
  owner_e            rr_last;
  owner_e            sel_own;
  logic [31:0]       sel_addr;
  logic              sel_bad;
  logic              issue;
  logic [ADDR_W-1:0] addr_q;
  stage_t            s1;
  stage_t            s2;
  logic              if_hit;
  logic              dp_hit;

  // a flushing IF port never competes, so DP can take the slot
  assign req    = reset ? 2'b00 : {dp_valid, if_valid & ~if_flush};
  assign accept = |gnt;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .accept  (accept),
    .gnt     (gnt),
    .rr_last (rr_last)
  );

  assign if_ready = gnt[0];
  assign dp_ready = gnt[1];
  assign sel_own  = gnt_owner(gnt);
  assign sel_addr = gnt[1] ? dp_addr : if_addr;

`ifdef IMEM_RD_ARB_ADDR_CHK_EN
  assign sel_bad = (sel_addr[1:0] != 2'b00) || (sel_addr[31:ADDR_W+2] != '0);
`else
  assign sel_bad = 1'b0;
`endif

  assign issue    = accept & ~sel_bad;
  assign mem_en   = issue;
  assign mem_addr = reset ? '0 : (issue ? sel_addr[ADDR_W+1:2] : addr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= '0;
    end else if (issue) begin
      addr_q <= sel_addr[ADDR_W+1:2];
    end
  end

  // S1 carries the tag while the memory reads; S2 holds the returned data
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1.valid <= accept;
      s1.owner <= sel_own;
      s1.err   <= sel_bad;
      s1.data  <= '0;
      s2.valid <= s1.valid & ~(if_flush & (s1.owner == OWN_IF));
      s2.owner <= s1.owner;
      s2.err   <= s1.err;
      s2.data  <= s1.err ? NOP_INSTR : mem_rdata;
    end
  end

  // the flush also hides an IF response being presented in the flush cycle
  assign if_hit = ~reset & s2.valid & (s2.owner == OWN_IF) & ~if_flush;
  assign dp_hit = ~reset & s2.valid & (s2.owner == OWN_DP);

  assign if_rsp_valid = if_hit;
  assign dp_rsp_valid = dp_hit;
  assign if_rsp_data  = if_hit ? s2.data : '0;
  assign dp_rsp_data  = dp_hit ? s2.data : '0;

`ifdef IMEM_RD_ARB_ADDR_CHK_EN
  assign if_rsp_err = if_hit & s2.err;
  assign dp_rsp_err = dp_hit & s2.err;
`else
  assign if_rsp_err = 1'b0;
  assign dp_rsp_err = 1'b0;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0], s2.err};
`endif

  logic unused_s1_data;
  assign unused_s1_data = ^{s1.data, rr_last};

endmodule
